// File: rtl/key_led_pattern.sv
`default_nettype none
// ============================================================================
// Module   : key_led_pattern
// Purpose  : Debounces two active-low push keys (key[0] = MODE, key[1] = PAUSE)
//            and drives an LED bus with one of four patterns: OFF, BLINK,
//            ALTERNATE or RUN. The pattern steps once every TICK_MAX cycles
//            and can be paused.
// Options  : KEY_LED_PINGPONG_EN - when defined, RUN bounces between the end
//            LEDs instead of wrapping from the top LED back to LED 0.
// Revision : 1.0 - initial release
// ============================================================================
module key_led_pattern #(
    parameter int LED_W    = 4,
    parameter int TICK_MAX = 25_000_000,
    parameter int DEB_MAX  = 1_000_000
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [1:0]       key,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             paused
);

    localparam int TICK_W = $clog2(TICK_MAX);
    localparam int DEB_W  = $clog2(DEB_MAX);
    localparam int POS_W  = $clog2(LED_W);

    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(TICK_MAX - 1);
    localparam logic [DEB_W-1:0]  c_DEB_LAST  = DEB_W'(DEB_MAX - 1);
    localparam logic [POS_W-1:0]  c_POS_LAST  = POS_W'(LED_W - 1);

    localparam logic [1:0] c_MODE_OFF   = 2'd0;
    localparam logic [1:0] c_MODE_BLINK = 2'd1;
    localparam logic [1:0] c_MODE_ALT   = 2'd2;
    localparam logic [1:0] c_MODE_RUN   = 2'd3;

    // One-cycle press pulses out of the debouncers: bit 0 MODE, bit 1 PAUSE
    logic [1:0] w_press;

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic             r_meta;
        logic             r_sync;
        logic             r_stable;
        logic             r_press;
        logic [DEB_W-1:0] r_cnt;

        // Two-flop synchroniser, then accept a level only after DEB_MAX
        // consecutive differing samples; a 1->0 acceptance is a press.
        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
                r_meta   <= 1'b1;
                r_sync   <= 1'b1;
                r_stable <= 1'b1;
                r_press  <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_meta  <= key[gi];
                r_sync  <= r_meta;
                r_press <= 1'b0;
                if (r_sync == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_stable <= r_sync;
                    r_cnt    <= '0;
                    // Old stable level 1 means this flip is a release->press
                    r_press  <= r_stable;
                end else begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    logic w_mode_press;
    logic w_pause_press;
    assign w_mode_press  = w_press[0];
    assign w_pause_press = w_press[1];

    // ALTERNATE phase-0 pattern: every even-numbered LED lit
    logic [LED_W-1:0] w_alt_even;
    for (genvar gb = 0; gb < LED_W; gb++) begin : g_alt
        assign w_alt_even[gb] = ((gb % 2) == 0);
    end

    logic [1:0]        r_mode;
    logic              r_paused;
    logic              r_phase;
    logic [POS_W-1:0]  r_pos;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [LED_W-1:0]  r_led;
    logic [POS_W-1:0]  w_pos_step;
    logic              w_tick;
    logic [LED_W-1:0]  w_pattern;

    assign w_tick = (r_tick_cnt == c_TICK_LAST) && !r_paused;

`ifdef KEY_LED_PINGPONG_EN
    logic r_dir_up;
    logic w_turn;

    // At an end LED the next step heads back the other way
    assign w_turn     = r_dir_up ? (r_pos == c_POS_LAST) : (r_pos == '0);
    assign w_pos_step = (r_dir_up ^ w_turn) ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));

    // RUN direction: restarts upward on every MODE press, flips at the ends
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_dir_up <= 1'b1;
        end else if (w_mode_press) begin
            r_dir_up <= 1'b1;
        end else if (w_tick && (r_mode == c_MODE_RUN) && w_turn) begin
            r_dir_up <= ~r_dir_up;
        end
    end
`else
    assign w_pos_step = (r_pos == c_POS_LAST) ? '0 : (r_pos + POS_W'(1));
`endif

    // Display pattern for the current mode/phase/position
    always_comb begin
        w_pattern = '0;
        case (r_mode)
            c_MODE_OFF:   w_pattern = '0;
            c_MODE_BLINK: w_pattern = {LED_W{~r_phase}};
            c_MODE_ALT:   w_pattern = r_phase ? ~w_alt_even : w_alt_even;
            c_MODE_RUN:   w_pattern = {{(LED_W-1){1'b0}}, 1'b1} << r_pos;
            default:      w_pattern = '0;
        endcase
    end

    // Mode, pause, tick counter and pattern stepping; MODE overrides PAUSE
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_mode     <= c_MODE_OFF;
            r_paused   <= 1'b0;
            r_phase    <= 1'b0;
            r_pos      <= '0;
            r_tick_cnt <= '0;
            r_led      <= '0;
        end else begin
            r_led <= w_pattern;
            if (w_mode_press) begin
                r_mode     <= r_mode + 2'd1;
                r_paused   <= 1'b0;
                r_phase    <= 1'b0;
                r_pos      <= '0;
                r_tick_cnt <= '0;
            end else begin
                if (w_pause_press) begin
                    r_paused <= ~r_paused;
                end
                if (!r_paused) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        r_tick_cnt <= '0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                    end
                end
                if (w_tick) begin
                    case (r_mode)
                        c_MODE_BLINK, c_MODE_ALT: r_phase <= ~r_phase;
                        c_MODE_RUN:               r_pos   <= w_pos_step;
                        default:                  ;
                    endcase
                end
            end
        end
    end

    assign led    = r_led;
    assign mode   = r_mode;
    assign paused = r_paused;

endmodule
`default_nettype wire

// File: doc/key_led_pattern.md
# key_led_pattern

Parametrised key-controlled LED pattern generator for the board-level demo designs: it debounces two active-low push keys, steps through four LED display modes with a pause function, and drives an LED bus of configurable width at a configurable tick rate. It replaces fixed two-LED key/LED glue with a single reusable block between the board key pins and the LED pins.

## Interface
- `LED_W`, default 4: number of LEDs; legal range 2–32.
- `TICK_MAX`, default 25_000_000: `sys_clk` cycles per pattern step; legal minimum 2.
- `DEB_MAX`, default 1_000_000: consecutive stable cycles needed to accept a key level change; legal minimum 2.

Ports:
- `sys_clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `key`, input, 2: asynchronous keys, active-low; 1 means released. `key[0]` is MODE, `key[1]` is PAUSE.
- `led`, output, `LED_W`: LED drive, registered; 1 means lit.
- `mode`, output, 2: current mode, registered.
- `paused`, output, 1: pause status, registered.

## Operation
- **Synchroniser.** Each key passes through a 2-flop synchroniser.
- **Debouncer.** Each key has its own debouncer: a stable-state register (reset value 1) and a counter.
  - Each cycle the synced value differs from the stable state, the counter increments.
  - Any cycle where they are equal clears the counter.
  - On the cycle the counter would reach `DEB_MAX`, the stable state flips and the counter clears.
  - A 1→0 flip produces a one-cycle press pulse. A 0→1 flip (release) produces nothing.
- **MODE press.** Advances `mode` 0→1→2→3→0 (wraps). It also clears the tick counter and the phase/position state, and clears `paused`.
- **PAUSE press.** Toggles `paused`. While paused, the tick counter and the pattern hold; `led` is frozen.
- **Simultaneous presses.** If MODE and PAUSE press in the same cycle, MODE wins: the mode advances and `paused` = 0.
- **Tick counter.** Counts 0..`TICK_MAX`-1 and wraps. A tick is the cycle where count = `TICK_MAX`-1 and the block is not paused. Each tick advances the pattern by one step.
- **Modes**, shown for `LED_W`=4:
  - 0 OFF: `led` = 0 always. Ticks are ignored.
  - 1 BLINK: phase 0 gives all ones; phase 1 gives all zeros. Phase toggles each tick.
  - 2 ALTERNATE: phase 0 gives 0101 (bit0 set, even bits); phase 1 gives 1010. Phase toggles each tick.
  - 3 RUN: one-hot at position p. p starts at 0 and goes 0,1,..,`LED_W`-1, then wraps to 0.
- **Register widths.** Counter widths are `$clog2` of the respective maximum. The position register is `$clog2(LED_W)` bits. No arithmetic overflow is permitted.
- **Reset (asynchronous, any time, including mid-debounce).**
  - `led`=0, `mode`=0, `paused`=0.
  - Counters = 0, phase = 0, p = 0.
  - Sync flops and stable states = 1, which means a key held down through reset produces a press only after the full debounce following release of reset.

## Timing
- **Key low to mode change.** Key low and stable before clock edge E1:
  - The press pulse registers at edge E(2+`DEB_MAX`).
  - `mode` updates at edge E(3+`DEB_MAX`).
  - `led` shows the new mode's phase-0 pattern at edge E(4+`DEB_MAX`).
- **Tick to LED.** `led` changes at the edge after the tick cycle. The steady step period is exactly `TICK_MAX` cycles.
- **After a MODE press.** The first step occurs `TICK_MAX` cycles after the mode update.
- **Resume after pause.** The counter resumes from its frozen value; no step is lost or repeated.
- **Bounce rejection.** Bounces shorter than `DEB_MAX` cycles produce no pulse.

## Configuration
- `KEY_LED_PINGPONG_EN` defined: RUN mode bounces instead of wrapping.
  - p sequence: 0,1,..,`LED_W`-1,`LED_W`-2,..,0,1,…
  - A direction register (reset value: up) reverses at each end. It clears to up on a MODE press.
  - Sequence for `LED_W`=4: 0001,0010,0100,1000,0100,0010,0001,0010.
- Not defined: RUN wraps `LED_W`-1→0. No direction register exists.

## Test plan
Parameters for all scenarios: `LED_W`=4, `TICK_MAX`=4, `DEB_MAX`=3.

- **Reset values.** Assert `rst` mid-run with `key`=11 → `led`=0000, `mode`=0 and `paused`=0 immediately (asynchronous); after release, `led` stays 0000.
- **Debounce.** Glitch `key[0]` low for 2 cycles, then high → `mode` stays 0. Hold it low for 10 cycles → `mode`=1 at edge E6 and `led`=1111 at edge E7; `led` then toggles every 4 cycles.
- **Mode sequence.** Press MODE twice more → ALTERNATE shows 0101, 1010 alternating every 4 cycles. RUN shows 0001, 0010, 0100, 1000, 0001 (0001, …, 1000, 0100 with `KEY_LED_PINGPONG_EN`). A fourth press → `mode`=0 and `led`=0000.
- **Pause.** In RUN at 0100, press PAUSE → `paused`=1 and `led` holds for 20 cycles. Press PAUSE again → 1000 appears at exactly the remaining tick count.
- **Simultaneous presses.** While paused, press both keys on the same cycle → `mode` advances, `paused`=0, and the phase-0 pattern is shown.
- **Key held through reset.** Hold `key[0]` low through reset → `mode` increments once, `DEB_MAX`+3 cycles after reset deasserts; holding longer causes no further increment.
